// File: rtl/fp_const_sub_pipe_if.sv
// Handshake/data bundle for the constant-minus-x stage of the inverse-sqrt datapath.
//   valid           : float_in/float_in_delay valid this cycle
//   float_in        : subtrahend x (31-bit positive float)
//   float_in_delay  : companion operand carried alongside x
//   float_out       : C - x
//   float_out_delay : float_in_delay, delayed to line up with float_out
//   ready           : float_out/float_out_delay valid this cycle
//   clamp           : x >= C, float_out forced to zero (qualified by ready)
// master drives the inputs and observes the results; slave is the pipeline side.
interface fp_const_sub_pipe_if;
    logic        valid;
    logic [30:0] float_in;
    logic [30:0] float_in_delay;
    logic [30:0] float_out;
    logic [30:0] float_out_delay;
    logic        ready;
    logic        clamp;

    modport master (
        output valid, float_in, float_in_delay,
        input  float_out, float_out_delay, ready, clamp
    );

    modport slave (
        input  valid, float_in, float_in_delay,
        output float_out, float_out_delay, ready, clamp
    );
endinterface

// File: rtl/fp_const_sub_pipe.sv
// Newton-Raphson correction term: float_out = CONST - float_in, three-stage
// pipeline, one sample per clock, no stall. float_in_delay rides through
// untouched in lockstep with valid.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset, clears every pipeline register
//   io  : slave side of fp_const_sub_pipe_if (valid/float_in/float_in_delay in,
//         float_out/float_out_delay/ready/clamp out)
// Float format: [30:23] biased exponent (bias 127), [22:0] mantissa, hidden 1,
// positive values only. Result is truncated (round toward zero).
module fp_const_sub_pipe #(
    parameter logic [30:0] CONST = 31'h3FC00000
) (
    input  logic               clk,
    input  logic               rst,
    fp_const_sub_pipe_if.slave io
);

    localparam logic [7:0]  EC      = CONST[30:23];
    // Minuend significand with hidden one and three guard bits.
    localparam logic [26:0] MC_FULL = {1'b1, CONST[22:0], 3'b000};

    // ---------------- stage 1: compare / align ----------------
    logic [7:0]  ex;
    logic [7:0]  d;
    logic        x_zero;
    logic        x_ge;
    logic [26:0] mx_full;
    logic [26:0] mx_shift;

    always_comb begin
        ex       = io.float_in[30:23];
        x_zero   = (ex == '0);
        // For positive floats the raw word order equals numeric order.
        x_ge     = !x_zero && (io.float_in >= CONST);
        d        = EC - ex;
        mx_full  = {1'b1, io.float_in[22:0], 3'b000};
        mx_shift = '0;
        if (!x_zero && !x_ge && (d <= 8'd26))
            mx_shift = mx_full >> d;
    end

    logic        s1_valid;
    logic        s1_clamp;
    logic [26:0] s1_mx;
    logic [30:0] s1_delay;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_clamp <= 1'b0;
            s1_mx    <= '0;
            s1_delay <= '0;
        end else begin
            s1_valid <= io.valid;
            s1_clamp <= x_ge;
            s1_mx    <= mx_shift;
            s1_delay <= io.float_in_delay;
        end
    end

    // ---------------- stage 2: subtract / leading-zero count ----------------
    logic [26:0] diff;
    logic [4:0]  lz;

    always_comb begin
        diff = MC_FULL - s1_mx;
        // 27 means diff == 0; ascending scan so the highest set bit wins.
        lz = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (diff[i])
                lz = 5'(26 - i);
        end
    end

    logic        s2_valid;
    logic        s2_clamp;
    logic [26:0] s2_diff;
    logic [4:0]  s2_lz;
    logic [30:0] s2_delay;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_clamp <= 1'b0;
            s2_diff  <= '0;
            s2_lz    <= '0;
            s2_delay <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_clamp <= s1_clamp;
            s2_diff  <= diff;
            s2_lz    <= lz;
            s2_delay <= s1_delay;
        end
    end

    // ---------------- stage 3: normalise / pack ----------------
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_mant;
    logic [30:0]       result;

    always_comb begin
        norm_exp  = $signed({2'b00, EC}) - $signed({5'b00000, s2_lz});
        // Hidden one lands on bit 26; keep bits [25:3], drop the guard bits.
        norm_mant = 23'((s2_diff << s2_lz) >> 3);
        result    = {norm_exp[7:0], norm_mant};
        if (s2_clamp || (s2_diff == '0) || (norm_exp <= 10'sd0))
            result = '0;
    end

    // Outputs hold between samples; only ready is qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            io.ready           <= 1'b0;
            io.float_out       <= '0;
            io.float_out_delay <= '0;
            io.clamp           <= 1'b0;
        end else begin
            io.ready <= s2_valid;
            if (s2_valid) begin
                io.float_out       <= result;
                io.float_out_delay <= s2_delay;
                io.clamp           <= s2_clamp;
            end
        end
    end

endmodule

// File: tb/tb_fp_const_sub_pipe.sv
module tb_fp_const_sub_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_const_sub_pipe_if io ();

    fp_const_sub_pipe #(.CONST(31'h3FC00000)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [30:0] x, input logic [30:0] tag);
        io.valid          = v;
        io.float_in       = x;
        io.float_in_delay = tag;
    endtask

    // Exact 1.5 - x for x in [0.25,1.0], in units of 2^-25, then truncated pack.
    function automatic logic [30:0] ref_sub(input logic [30:0] x);
        logic [26:0] xs;
        logic [26:0] dv;
        int          p;
        logic [22:0] m;
        xs = 27'({1'b1, x[22:0]}) << (x[30:23] - 8'd125);
        dv = 27'h3000000 - xs;
        p  = 0;
        for (int i = 0; i < 27; i++)
            if (dv[i]) p = i;
        if (p >= 23) m = 23'(dv >> (p - 23));
        else         m = 23'(dv << (23 - p));
        return {8'(p + 102), m};
    endfunction

    typedef struct {
        logic [30:0] x;
        logic [30:0] out;
        logic        clamp;
    } vec_t;

    typedef struct {
        logic [30:0] out;
        logic [30:0] tag;
    } exp_t;

    vec_t vecs [13];
    exp_t sb [$];
    logic vhist [0:511];

    initial begin
        vecs[0]  = '{31'h3F000000, 31'h3F800000, 1'b0};
        vecs[1]  = '{31'h3FA00000, 31'h3E800000, 1'b0};
        vecs[2]  = '{31'h00000000, 31'h3FC00000, 1'b0};
        vecs[3]  = '{31'h30800000, 31'h3FC00000, 1'b0};
        vecs[4]  = '{31'h3FC00000, 31'h00000000, 1'b1};
        vecs[5]  = '{31'h40000000, 31'h00000000, 1'b1};
        vecs[6]  = '{31'h3FBFFFFF, 31'h34000000, 1'b0};
        vecs[7]  = '{31'h3FBFFFFE, 31'h34800000, 1'b0};
        vecs[8]  = '{31'h3FBFFFFD, 31'h34C00000, 1'b0};
        vecs[9]  = '{31'h3FBFFFFC, 31'h35000000, 1'b0};
        vecs[10] = '{31'h00123456, 31'h3FC00000, 1'b0};
        vecs[11] = '{31'h7F7FFFFF, 31'h00000000, 1'b1};
        vecs[12] = '{31'h3F800000, 31'h3F000000, 1'b0};

        // ---- reset state ----
        rst = 1'b1;
        drive(1'b0, '0, '0);
        step();
        step();
        check("rst_ready", {31'b0, io.ready}, 32'd0);
        check("rst_out",   {1'b0, io.float_out}, 32'd0);
        check("rst_delay", {1'b0, io.float_out_delay}, 32'd0);
        check("rst_clamp", {31'b0, io.clamp}, 32'd0);
        rst = 1'b0;
        step();

        // ---- isolated directed vectors: latency, value, clamp, tag, hold ----
        for (int i = 0; i < 13; i++) begin
            logic [30:0] tag;
            tag = 31'h12340000 | 31'(i);
            drive(1'b1, vecs[i].x, tag);
            step();
            drive(1'b0, 31'h7FFFFFFF, 31'h0);
            check($sformatf("vec%0d_lat1", i), {31'b0, io.ready}, 32'd0);
            step();
            check($sformatf("vec%0d_lat2", i), {31'b0, io.ready}, 32'd0);
            step();
            check($sformatf("vec%0d_ready", i), {31'b0, io.ready}, 32'd1);
            check($sformatf("vec%0d_out", i), {1'b0, io.float_out}, {1'b0, vecs[i].out});
            check($sformatf("vec%0d_clamp", i), {31'b0, io.clamp}, {31'b0, vecs[i].clamp});
            check($sformatf("vec%0d_tag", i), {1'b0, io.float_out_delay}, {1'b0, tag});
            step();
            check($sformatf("vec%0d_after", i), {31'b0, io.ready}, 32'd0);
            check($sformatf("vec%0d_hold", i), {1'b0, io.float_out}, {1'b0, vecs[i].out});
        end

        // ---- random stream with gaps ----
        begin
            int issued;
            int last_cyc;
            int c;
            issued   = 0;
            last_cyc = 0;
            for (c = 0; c < 400; c++) begin
                logic req_ready;
                req_ready = (c >= 3) ? vhist[c-3] : 1'b0;
                check("stream_ready", {31'b0, io.ready}, {31'b0, req_ready});
                if (io.ready) begin
                    if (sb.size() == 0) begin
                        check("stream_extra", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("stream_out", {1'b0, io.float_out}, {1'b0, e.out});
                        check("stream_tag", {1'b0, io.float_out_delay}, {1'b0, e.tag});
                        check("stream_clamp", {31'b0, io.clamp}, 32'd0);
                    end
                end
                if (issued == 64 && c >= last_cyc + 3)
                    break;
                if (issued < 64 && $urandom_range(0, 3) != 0) begin
                    logic [30:0] x;
                    logic [30:0] tag;
                    exp_t e;
                    if ($urandom_range(0, 15) == 0)
                        x = 31'h3F800000;
                    else
                        x = {8'($urandom_range(125, 126)), 23'($urandom)};
                    tag = 31'($urandom);
                    e.out = ref_sub(x);
                    e.tag = tag;
                    sb.push_back(e);
                    drive(1'b1, x, tag);
                    vhist[c] = 1'b1;
                    issued++;
                    last_cyc = c;
                end else begin
                    drive(1'b0, 31'h0, 31'h0);
                    vhist[c] = 1'b0;
                end
                step();
            end
            drive(1'b0, 31'h0, 31'h0);
            check("stream_drain", 32'(sb.size()), 32'd0);
            check("stream_count", 32'(issued), 32'd64);
        end
        step();

        // ---- reset with samples in flight ----
        drive(1'b1, 31'h40000000, 31'h0BADCAFE);  // clamp sample, reaches output before reset
        step();
        drive(1'b1, 31'h3F000000, 31'h00000A01);
        step();
        drive(1'b1, 31'h3FA00000, 31'h00000A02);
        step();
        drive(1'b1, 31'h3F800000, 31'h00000A03);
        rst = 1'b1;
        check("pre_rst_clamp", {31'b0, io.clamp}, 32'd1);
        step();
        rst = 1'b0;
        check("mid_rst_ready", {31'b0, io.ready}, 32'd0);
        check("mid_rst_out",   {1'b0, io.float_out}, 32'd0);
        check("mid_rst_delay", {1'b0, io.float_out_delay}, 32'd0);
        check("mid_rst_clamp", {31'b0, io.clamp}, 32'd0);
        drive(1'b1, 31'h3FA00000, 31'h00000B01);
        step();
        drive(1'b0, 31'h0, 31'h0);
        check("post_rst_r1", {31'b0, io.ready}, 32'd0);
        step();
        check("post_rst_r2", {31'b0, io.ready}, 32'd0);
        step();
        check("post_rst_ready", {31'b0, io.ready}, 32'd1);
        check("post_rst_out",   {1'b0, io.float_out}, 32'h3E800000);
        check("post_rst_tag",   {1'b0, io.float_out_delay}, 32'h00000B01);
        step();
        check("post_rst_idle",  {31'b0, io.ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
